// File: rtl/lock_code_entry.sv
// Front-end controller for a combination-lock core: synchronises and debounces the
// code switches and SET/TRY buttons, then runs program / compare sessions on the lock.
module lock_code_entry #(
  parameter int DB_CYC      = 20000,
  parameter int HOLD_CYC    = 50000,
  parameter int LOCKOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_set,
  input  logic       btn_try,
  input  logic       open_i,
  input  logic       alert_i,
  output logic [3:0] code_o,
  output logic       enlock_o,
  output logic       encmp_o,
  output logic       granted_o,
  output logic       denied_o,
  output logic [2:0] state_o
);

  localparam int DBW       = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
  localparam int DWELL_MAX = (HOLD_CYC > LOCKOUT_CYC) ? HOLD_CYC : LOCKOUT_CYC;
  localparam int DWW       = (DWELL_MAX > 2) ? $clog2(DWELL_MAX) : 1;

  localparam logic [DBW-1:0] DB_TERM   = DBW'(DB_CYC - 1);
  localparam logic [DWW-1:0] HOLD_TERM = DWW'(HOLD_CYC - 1);
  localparam logic [DWW-1:0] LOCK_TERM = DWW'(LOCKOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_TRY   = 3'd2,
    ST_GRANT = 3'd3,
    ST_DENY  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [5:0]       raw, sync1, sync2, deb, deb_q;
  logic [DBW-1:0]   db_cnt [6];
  logic [DWW-1:0]   dwell;
  logic [3:0]       code_q;
  logic             set_ev, try_ev;

  assign raw = {btn_try, btn_set, sw};

  // Debounce: the counter only advances while the synchronised input disagrees
  // with the debounced value, so any bounce back restarts the qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TERM) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign set_ev = deb[4] & ~deb_q[4];
  assign try_ev = deb[5] & ~deb_q[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      dwell  <= '0;
      code_q <= '0;
    end else begin
      state <= state_next;
      if (state != state_next) dwell <= '0;
      else if (dwell != '1)    dwell <= dwell + DWW'(1);
      // The code only tracks the switches while idle so A..D hold still during a compare.
      if (state == ST_IDLE) code_q <= deb[3:0];
    end
  end

  always_comb begin
    state_next = state;
    enlock_o   = 1'b0;
    encmp_o    = 1'b0;
    granted_o  = 1'b0;
    denied_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (set_ev)       state_next = ST_SET;
        else if (alert_i) state_next = ST_HALT;
        else if (try_ev)  state_next = ST_TRY;
      end
      ST_SET: begin
        enlock_o   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_TRY: begin
        // Single-cycle compare: a wrong code costs the lock exactly one attempt.
        encmp_o = 1'b1;
        if (open_i)       state_next = ST_GRANT;
        else if (alert_i) state_next = ST_HALT;
        else              state_next = ST_DENY;
      end
      ST_GRANT: begin
        encmp_o   = 1'b1;
        granted_o = 1'b1;
        if (!open_i || dwell == HOLD_TERM) state_next = ST_IDLE;
      end
      ST_DENY: begin
        denied_o = 1'b1;
        if (dwell == LOCK_TERM) state_next = alert_i ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (set_ev) state_next = ST_SET;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign code_o  = code_q;
  assign state_o = state;

endmodule

// File: tb/tb_lock_code_entry.sv
// Bench for lock_code_entry: directed sessions plus random tries against a
// behavioural lock core and a session-level reference of key and attempts.
module tb_lock_code_entry;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int LOCK = 16;
  localparam int MAX_ATT = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic       btn_set = 1'b0, btn_try = 1'b0;
  logic       open_i, alert_i;
  logic [3:0] code_o;
  logic       enlock_o, encmp_o, granted_o, denied_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  lock_code_entry #(.DB_CYC(DB), .HOLD_CYC(HOLD), .LOCKOUT_CYC(LOCK)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_set(btn_set), .btn_try(btn_try),
    .open_i(open_i), .alert_i(alert_i), .code_o(code_o), .enlock_o(enlock_o),
    .encmp_o(encmp_o), .granted_o(granted_o), .denied_o(denied_o), .state_o(state_o)
  );

  // ---------------- behavioural lock core ----------------
  logic [3:0] lk_key = '0;
  int         lk_att = MAX_ATT;

  always @(posedge clk) begin
    if (enlock_o) begin
      lk_key <= code_o;
      lk_att <= MAX_ATT;
    end else if (encmp_o && code_o != lk_key && lk_att > 0) begin
      lk_att <= lk_att - 1;
    end
  end

  assign open_i  = encmp_o && (code_o == lk_key) && (lk_att > 0);
  assign alert_i = (lk_att == 0);

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   tot_enl = 0, tot_cmp = 0, tot_gr = 0, tot_dn = 0, tot_ovl = 0;
  int   enl_rise = -1, cmp_rise = -1;
  int   cmp_code = -1;
  logic enl_q = 1'b0, cmp_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enlock_o) tot_enl <= tot_enl + 1;
    if (encmp_o)  tot_cmp <= tot_cmp + 1;
    if (granted_o) tot_gr <= tot_gr + 1;
    if (denied_o)  tot_dn <= tot_dn + 1;
    if (enlock_o && encmp_o) tot_ovl <= tot_ovl + 1;
    if (enlock_o && !enl_q) enl_rise <= cyc;
    if (encmp_o && !cmp_q) begin
      cmp_rise <= cyc;
      cmp_code <= int'(code_o);
    end
    enl_q <= enlock_o;
    cmp_q <= encmp_o;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  int e0, c0, g0, d0, start;
  logic [3:0] ref_key = '0;
  int         ref_att = MAX_ATT;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    e0 = tot_enl; c0 = tot_cmp; g0 = tot_gr; d0 = tot_dn; start = cyc;
  endtask

  task automatic set_code(input logic [3:0] v);
    sw = v;
    tick(DB + 6);
  endtask

  task automatic press(input bit s, input bit t, input int hold, input int settle);
    btn_set = s;
    btn_try = t;
    tick(hold);
    btn_set = 1'b0;
    btn_try = 1'b0;
    tick(settle);
  endtask

  function automatic logic [3:0] wrong_code(input logic [3:0] key);
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if (v == key) v = v ^ 4'($urandom_range(1, 15));
    return v;
  endfunction

  // One try from IDLE, expectations derived from the reference key/attempts.
  task automatic try_session(input string tag);
    bit good;
    good = (sw == ref_key) && (ref_att > 0);
    mark();
    press(1'b0, 1'b1, $urandom_range(6, 10), 24);
    check({tag, "_cmp_cycles"}, tot_cmp - c0, good ? HOLD + 1 : 1);
    check({tag, "_grant_cycles"}, tot_gr - g0, good ? HOLD : 0);
    check({tag, "_deny_cycles"}, tot_dn - d0, good ? 0 : LOCK);
    check({tag, "_cmp_code"}, cmp_code, int'(sw));
    if (!good) ref_att--;
    check({tag, "_attempts"}, lk_att, ref_att);
    check({tag, "_state"}, int'(state_o), (ref_att == 0) ? 5 : 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] last_wrong, fresh;
    int waited;

    tick(3);
    check("rst_state", int'(state_o), 0);
    check("rst_outs", int'({code_o, enlock_o, encmp_o, granted_o, denied_o}), 0);
    rst = 1'b0;
    tick(2);

    // 1: program key 1010
    set_code(4'b1010);
    check("t1_code_idle", int'(code_o), 4'b1010);
    mark();
    btn_set = 1'b1;
    tick(10);
    btn_set = 1'b0;
    tick(12);
    check("t1_enlock_cycles", tot_enl - e0, 1);
    check("t1_enlock_latency", enl_rise - start, DB + 3);
    check("t1_key", int'(lk_key), 4'b1010);
    check("t1_state", int'(state_o), 0);
    ref_key = 4'b1010;
    ref_att = MAX_ATT;

    // 2: glitch on try is filtered
    mark();
    press(1'b0, 1'b1, 2, 12);
    check("t2_cmp_cycles", tot_cmp - c0, 0);
    check("t2_state", int'(state_o), 0);

    // 3: correct code grants
    mark();
    press(1'b0, 1'b1, 10, 20);
    check("t3_cmp_latency", cmp_rise - start, DB + 3);
    check("t3_cmp_cycles", tot_cmp - c0, HOLD + 1);
    check("t3_grant_cycles", tot_gr - g0, HOLD);
    check("t3_state", int'(state_o), 0);

    // 4: wrong code, second try inside the lockout is dropped
    set_code(4'b0110);
    mark();
    press(1'b0, 1'b1, 6, 7);
    press(1'b0, 1'b1, 6, 24);
    ref_att--;
    check("t4_cmp_cycles", tot_cmp - c0, 1);
    check("t4_deny_cycles", tot_dn - d0, LOCK);
    check("t4_attempts", lk_att, ref_att);
    check("t4_state", int'(state_o), 0);

    // 5: exhaust attempts -> HALT
    last_wrong = 4'b0110;
    while (ref_att > 0) begin
      last_wrong = wrong_code(ref_key);
      set_code(last_wrong);
      try_session("t5");
    end
    check("t5_alert", int'(alert_i), 1);
    mark();
    press(1'b0, 1'b1, 8, 12);
    check("t5_halt_try_cmp", tot_cmp - c0, 0);
    check("t5_halt_state", int'(state_o), 5);
    fresh = wrong_code(last_wrong);
    set_code(fresh);
    check("t5_code_frozen", int'(code_o), int'(last_wrong));
    mark();
    press(1'b1, 1'b0, 8, 12);
    ref_key = last_wrong;
    ref_att = MAX_ATT;
    check("t5_enlock_cycles", tot_enl - e0, 1);
    check("t5_key", int'(lk_key), int'(ref_key));
    check("t5_alert_clear", int'(alert_i), 0);
    check("t5_state", int'(state_o), 0);
    check("t5_code_follow", int'(code_o), int'(fresh));

    // 6: simultaneous set/try -> set wins
    fresh = 4'($urandom_range(0, 15));
    set_code(fresh);
    mark();
    press(1'b1, 1'b1, 8, 12);
    ref_key = fresh;
    check("t6_enlock_cycles", tot_enl - e0, 1);
    check("t6_cmp_cycles", tot_cmp - c0, 0);
    check("t6_key", int'(lk_key), int'(ref_key));

    // 6b: reset in the middle of GRANT
    btn_try = 1'b1;
    waited = 0;
    while (!granted_o && waited < 40) begin
      tick(1);
      waited++;
    end
    check("t6_grant_reached", int'(granted_o), 1);
    tick(2);
    rst = 1'b1;
    btn_try = 1'b0;
    tick(1);
    check("t6_rst_state", int'(state_o), 0);
    check("t6_rst_outs", int'({code_o, enlock_o, encmp_o, granted_o, denied_o}), 0);
    rst = 1'b0;
    tick(DB + 8);

    // random tries against the reference
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) exp_q.push_back(ref_key);
      else exp_q.push_back(wrong_code(ref_key));
      set_code(exp_q.pop_front());
      try_session("rnd");
      if (ref_att < 2) begin
        mark();
        press(1'b1, 1'b0, 8, 12);
        ref_key = code_o;
        ref_att = MAX_ATT;
        check("rnd_rearm", lk_att, ref_att);
      end
    end

    check("no_overlap", tot_ovl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
